// File: rtl/score_keeper_pkg.sv
// Shared Pong definitions used by score_keeper: rally states, the 4-bit score type and player encoding.
package score_keeper_pkg;

   typedef enum logic [1:0] {
      SERVE_WAIT = 2'd0,
      PLAY       = 2'd1,
      OVER       = 2'd2
   } state_e;

   typedef logic [3:0] score_t;

   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Frame/miss inputs and score/serve outputs of score_keeper; the score stage is the slave side.
interface score_keeper_if;
   import score_keeper_pkg::*;

   logic   frame_tick;
   logic   pausa;
   logic   miss_left;
   logic   miss_right;
   score_t point1;
   score_t point2;
   logic   serve;
   logic   serve_dir;
   logic   game_over;
   logic   winner;

   modport master (
      output frame_tick, pausa, miss_left, miss_right,
      input  point1, point2, serve, serve_dir, game_over, winner
   );

   modport slave (
      input  frame_tick, pausa, miss_left, miss_right,
      output point1, point2, serve, serve_dir, game_over, winner
   );

endinterface

// File: rtl/score_keeper_edge_detect.sv
// Single-bit rising-edge detector; the pulse is registered, so it appears one cycle after the input rises.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise
);

   logic sig_q;
   logic sig_d;
   logic rise_q;
   logic rise_d;

   always_comb begin
      sig_d  = sig_in;
      rise_d = sig_in & ~sig_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sig_q  <= sig_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/score_keeper.sv
// Pong score stage: counts points from miss edges, paces serves and holds the game-over phase.
// Build option: SCORE_SERVE_TO_LOSER_EN serves toward the player who lost the point instead of the scorer.
//
// state      | meaning
// SERVE_WAIT | counting frame ticks down to the next serve
// PLAY       | ball in play, miss edges award points
// OVER       | winner shown, counting down before scores clear
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter int WIN_SCORE    = 10,
   parameter int SERVE_FRAMES = 60,
   parameter int OVER_FRAMES  = 180
) (
   input  logic           clk,
   input  logic           rst,
   score_keeper_if.slave  bus
);

   localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, OVER_FRAMES) + 1);

   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0] OVER_LOAD  = CNT_W'(OVER_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam score_t           WIN        = score_t'(WIN_SCORE);

   localparam logic [1:0] ST_SERVE_WAIT = SERVE_WAIT;
   localparam logic [1:0] ST_PLAY       = PLAY;
   localparam logic [1:0] ST_OVER       = OVER;

   logic             rise_left;
   logic             rise_right;
   logic             tick_en;

   logic [1:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   score_t           point1_q,  point1_d;
   score_t           point2_q,  point2_d;
   logic             serve_q,   serve_d;
   logic             dir_q,     dir_d;
   logic             over_q,    over_d;
   logic             winner_q,  winner_d;

   logic             scorer;
   score_t           new_score;

   edge_detect u_edge_left (
      .clk    (clk),
      .rst    (rst),
      .sig_in (bus.miss_left),
      .rise   (rise_left)
   );

   edge_detect u_edge_right (
      .clk    (clk),
      .rst    (rst),
      .sig_in (bus.miss_right),
      .rise   (rise_right)
   );

   // A tick arriving while paused is dropped, not held for later.
   assign tick_en = bus.frame_tick & ~bus.pausa;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      point1_d  = point1_q;
      point2_d  = point2_q;
      serve_d   = 1'b0;
      dir_d     = dir_q;
      over_d    = over_q;
      winner_d  = winner_q;
      scorer    = rise_left ? P2 : P1;
      new_score = (scorer == P1) ? point1_q : point2_q;

      case (state_q)
         ST_SERVE_WAIT: begin
            if (tick_en) begin
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_PLAY;
                  serve_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end

         ST_PLAY: begin
            if (!bus.pausa && (rise_left || rise_right)) begin
               state_d = ST_SERVE_WAIT;
               cnt_d   = SERVE_LOAD;
               if (!(rise_left && rise_right)) begin
                  if (new_score < WIN) begin
                     new_score = new_score + score_t'(1);
                  end
                  if (scorer == P1) begin
                     point1_d = new_score;
                  end else begin
                     point2_d = new_score;
                  end
                  if (new_score == WIN) begin
                     state_d  = ST_OVER;
                     cnt_d    = OVER_LOAD;
                     over_d   = 1'b1;
                     winner_d = scorer;
                     dir_d    = ~scorer;
                  end else begin
`ifdef SCORE_SERVE_TO_LOSER_EN
                     dir_d = ~scorer;
`else
                     dir_d = scorer;
`endif
                  end
               end
            end
         end

         ST_OVER: begin
            if (tick_en) begin
               if (cnt_q == CNT_ONE) begin
                  state_d  = ST_SERVE_WAIT;
                  cnt_d    = SERVE_LOAD;
                  point1_d = '0;
                  point2_d = '0;
                  over_d   = 1'b0;
                  winner_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end

         default: begin
            state_d = ST_SERVE_WAIT;
            cnt_d   = SERVE_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SERVE_WAIT;
         cnt_q    <= SERVE_LOAD;
         point1_q <= '0;
         point2_q <= '0;
         serve_q  <= 1'b0;
         dir_q    <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         point1_q <= point1_d;
         point2_q <= point2_d;
         serve_q  <= serve_d;
         dir_q    <= dir_d;
         over_q   <= over_d;
         winner_q <= winner_d;
      end
   end

   assign bus.point1    = point1_q;
   assign bus.point2    = point2_q;
   assign bus.serve     = serve_q;
   assign bus.serve_dir = dir_q;
   assign bus.game_over = over_q;
   assign bus.winner    = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a rule-level model queues expected output events, a monitor checks them.
module tb_score_keeper;
   import score_keeper_pkg::*;

   localparam int WIN     = 10;
   localparam int SERVE_N = 60;
   localparam int OVER_N  = 180;
   localparam int PH_WAIT = 0;
   localparam int PH_PLAY = 1;
   localparam int PH_OVER = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   score_keeper_if bus();

   score_keeper #(
      .WIN_SCORE    (WIN),
      .SERVE_FRAMES (SERVE_N),
      .OVER_FRAMES  (OVER_N)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic [3:0]  p1;
      logic [3:0]  p2;
      logic        over;
      logic        win;
      logic        dir;
      logic        serve;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;

   // reference model: game rules in terms of players, scores and frames remaining
   int  phase = PH_WAIT;
   int  left  = SERVE_N;
   int  sc[2] = '{0, 0};
   bit  m_over = 0, m_win = 0, m_dir = 0, m_serve = 0;
   bit  last_l = 0, last_r = 0, pend_l = 0, pend_r = 0;
   ev_t m_last = '0;

   function automatic bit same_state(ev_t a, ev_t b);
      return (a.p1 == b.p1) && (a.p2 == b.p2) && (a.over == b.over) &&
             (a.win == b.win) && (a.dir == b.dir);
   endfunction

   function automatic ev_t model_view();
      ev_t e;
      e.cyc   = 32'(cyc);
      e.p1    = 4'(sc[0]);
      e.p2    = 4'(sc[1]);
      e.over  = m_over;
      e.win   = m_win;
      e.dir   = m_dir;
      e.serve = m_serve;
      return e;
   endfunction

   task automatic model_reset();
      phase = PH_WAIT; left = SERVE_N; sc[0] = 0; sc[1] = 0;
      m_over = 0; m_win = 0; m_dir = 0; m_serve = 0;
      last_l = 0; last_r = 0; pend_l = 0; pend_r = 0;
      m_last = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit  el, er, run;
      int  who;
      ev_t now;
      cyc++;
      el = pend_l;
      er = pend_r;
      pend_l = bus.miss_left  && !last_l;  last_l = bus.miss_left;
      pend_r = bus.miss_right && !last_r;  last_r = bus.miss_right;
      run = bus.frame_tick && !bus.pausa;
      m_serve = 0;
      if (phase == PH_WAIT) begin
         if (run) begin
            left--;
            if (left == 0) begin m_serve = 1; phase = PH_PLAY; end
         end
      end else if (phase == PH_PLAY) begin
         if (!bus.pausa && (el || er)) begin
            phase = PH_WAIT;
            left  = SERVE_N;
            if (!(el && er)) begin
               who = er ? 0 : 1;
               if (sc[who] < WIN) sc[who]++;
               if (sc[who] == WIN) begin
                  phase = PH_OVER; left = OVER_N;
                  m_over = 1; m_win = (who == 1); m_dir = (who == 0);
               end else begin
`ifdef SCORE_SERVE_TO_LOSER_EN
                  m_dir = (who == 0);
`else
                  m_dir = (who == 1);
`endif
               end
            end
         end
      end else begin
         if (run) begin
            left--;
            if (left == 0) begin
               sc[0] = 0; sc[1] = 0; m_over = 0; m_win = 0;
               phase = PH_WAIT; left = SERVE_N;
            end
         end
      end
      now = model_view();
      if (m_serve || !same_state(now, m_last)) exp_q.push_back(now);
      m_last = now;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   initial begin : monitor
      ev_t obs;
      ev_t e;
      ev_t prev_obs;
      prev_obs = '0;
      forever begin
         @(negedge clk);
         obs.cyc   = 32'(cyc);
         obs.p1    = bus.point1;
         obs.p2    = bus.point2;
         obs.over  = bus.game_over;
         obs.win   = bus.winner;
         obs.dir   = bus.serve_dir;
         obs.serve = bus.serve;
         if (rst) begin
            prev_obs = '0;
         end else begin
            if (obs.serve || !same_state(obs, prev_obs)) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_output cyc=%0d got p1=%0d p2=%0d over=%0b win=%0b dir=%0b serve=%0b, required no change",
                           obs.cyc, obs.p1, obs.p2, obs.over, obs.win, obs.dir, obs.serve);
               end else begin
                  e = exp_q.pop_front();
                  if (e != obs) begin
                     n_fail++;
                     $display("FAIL output_event got cyc=%0d p1=%0d p2=%0d over=%0b win=%0b dir=%0b serve=%0b required cyc=%0d p1=%0d p2=%0d over=%0b win=%0b dir=%0b serve=%0b",
                              obs.cyc, obs.p1, obs.p2, obs.over, obs.win, obs.dir, obs.serve,
                              e.cyc, e.p1, e.p2, e.over, e.win, e.dir, e.serve);
                  end
               end
            end
            prev_obs = obs;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1;
      idle(1);
      bus.frame_tick = 1'b0;
      idle($urandom_range(0, 2));
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic to_play();
      int k = 0;
      while (phase != PH_PLAY && k < 400) begin tick(); k++; end
      if (phase != PH_PLAY) begin
         n_checks++; n_fail++;
         $display("FAIL serve_timeout got no serve after %0d ticks, required serve", k);
      end
   endtask

   task automatic miss_pulse(input bit l, input bit r, input int hold);
      bus.miss_left  = l;
      bus.miss_right = r;
      idle(hold);
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      idle(2);
   endtask

   task automatic check_reset(input string name);
      logic [14:0] got;
      got = {bus.point1, bus.point2, bus.serve, bus.serve_dir, bus.game_over, bus.winner, 3'b000};
      n_checks++;
      if (got != 15'd0) begin
         n_fail++;
         $display("FAIL %s got p1=%0d p2=%0d serve=%0b dir=%0b over=%0b win=%0b, required all zero",
                  name, bus.point1, bus.point2, bus.serve, bus.serve_dir, bus.game_over, bus.winner);
      end
   endtask

   initial begin : driver
      int k;
      bit prev_tick;
      bus.frame_tick = 1'b0;
      bus.pausa      = 1'b0;
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      rst = 1'b1;
      idle(3);
      check_reset("reset_values");
      rst = 1'b0;
      idle(2);

      // first serve after exactly SERVE_N ticks
      ticks(SERVE_N);
      idle(3);

      // held miss scores once
      miss_pulse(1'b0, 1'b1, 5);
      idle(2);

      // simultaneous misses: no score, rally restarts
      to_play();
      miss_pulse(1'b1, 1'b1, 3);
      to_play();

      // pause freezes the countdown and blocks scoring
      miss_pulse(1'b0, 1'b1, 2);
      bus.pausa = 1'b1;
      ticks(30);
      bus.pausa = 1'b0;
      to_play();
      bus.pausa = 1'b1;
      idle(2);
      miss_pulse(1'b1, 1'b0, 2);
      idle(3);
      bus.pausa = 1'b0;
      idle(2);

      // player 2 wins, game-over hold, then fresh serve
      k = 0;
      while (sc[1] < WIN && k < 20) begin
         to_play();
         miss_pulse(1'b1, 1'b0, 2);
         k++;
      end
      k = 0;
      while (phase == PH_OVER && k < 400) begin tick(); k++; end
      to_play();

      // reach point1=7, then reset in the middle of a countdown
      k = 0;
      while (sc[0] < 7 && k < 20) begin
         to_play();
         miss_pulse(1'b0, 1'b1, 2);
         k++;
      end
      ticks(30);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // randomized play
      prev_tick = 1'b0;
      repeat (3000) begin
         bus.frame_tick = !prev_tick && ($urandom_range(0, 2) == 0);
         prev_tick = bus.frame_tick;
         if ($urandom_range(0, 15) == 0) bus.pausa      = ~bus.pausa;
         if ($urandom_range(0, 7)  == 0) bus.miss_left  = ~bus.miss_left;
         if ($urandom_range(0, 7)  == 0) bus.miss_right = ~bus.miss_right;
         idle(1);
      end
      bus.frame_tick = 1'b0;
      bus.pausa      = 1'b0;
      bus.miss_left  = 1'b0;
      bus.miss_right = 1'b0;
      idle(6);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_events got %0d unseen expected events, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Point-tracking stage of the Pong datapath. Converts ball-miss events from the ball/collision logic into the two 4-bit player scores consumed by the game-reset and pause logic downstream. Sequences each rally with a serve countdown, freezes while the game is paused, and holds a game-over phase before clearing scores. Drives the serve pulse and serve direction back to the ball engine.

## Interface
- WIN_SCORE, 10: score that ends the game; legal range 1..15.
- SERVE_FRAMES, 60: frame ticks between a point (or reset) and the next serve; ≥1.
- OVER_FRAMES, 180: frame ticks the game-over phase is held; ≥1.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset; board reset only, never the downstream game-reset output.
- frame_tick  in  1  one-cycle pulse per video frame.
- pausa  in  1  level, 1 = game paused (from the pause stage).
- miss_left  in  1  level, ball past left wall; player 2 scores.
- miss_right  in  1  level, ball past right wall; player 1 scores.
- point1  out  4  player 1 score.
- point2  out  4  player 2 score.
- serve  out  1  one-cycle pulse: launch ball.
- serve_dir  out  1  0 = toward player 1 (left), 1 = toward player 2 (right).
- game_over  out  1  high throughout OVER state.
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over.

## Operation
- Miss inputs are rising-edge detected using registered copies. Registers reset to 0, so an input already high at reset release counts once.
- State SERVE_WAIT:
  - Entered on reset, after a point, and after OVER.
  - Counter loads SERVE_FRAMES on entry and decrements on each frame_tick while pausa=0.
  - When the counter reaches 0 on a tick, serve pulses for one cycle and the state moves to PLAY.
  - Miss edges are ignored in this state.
- State PLAY:
  - Miss edges are accepted only while pausa=0.
  - miss_right edge: point1++. miss_left edge: point2++.
  - Both edges in the same cycle: no score; go to SERVE_WAIT with serve_dir unchanged.
  - If the incremented score equals WIN_SCORE: go to OVER, set winner, assert game_over.
  - Otherwise go to SERVE_WAIT.
- State OVER:
  - Counter loads OVER_FRAMES and decrements on frame_tick while pausa=0. Miss edges are ignored.
  - When the counter reaches 0, clear point1, point2, winner and game_over, then go to SERVE_WAIT.
- Scores saturate at WIN_SCORE and never wrap.
- Counter width is $clog2(max(SERVE_FRAMES, OVER_FRAMES)+1).

## Timing
- Reset values: point1=0, point2=0, serve=0, serve_dir=0, game_over=0, winner=0, state=SERVE_WAIT, counter=SERVE_FRAMES.
- Miss input rising at cycle N: the score, state and game_over change at the clock edge ending cycle N+1 (one edge-detect register plus the update).
- serve is asserted in the cycle after the counter-0 tick; exactly one cycle wide.
- pausa high freezes the counter. A frame_tick coincident with pausa=1 is lost, not deferred.
- Reset asserted mid-operation clears everything immediately. No serve is emitted during reset.

## Configuration
- SCORE_SERVE_TO_LOSER_EN defined: after a point, serve_dir points toward the player who lost the point (player 1 scored → serve_dir=1).
- SCORE_SERVE_TO_LOSER_EN undefined: serve_dir points toward the player who scored (player 1 scored → serve_dir=0).
- In both builds, serve_dir after OVER points toward the game loser.

## Structure
- Shared pong package holds:
  - state enum {SERVE_WAIT, PLAY, OVER};
  - the 4-bit score type;
  - player encoding constants P1=0, P2=1.
- One sub-module, edge_detect (single-bit rising-edge detector, async reset), instantiated once per miss input.

## Test plan
- Release reset, issue 60 frame_ticks with pausa=0 → single serve pulse after the 60th tick, serve_dir=0, state PLAY.
- In PLAY, hold miss_right high for 5 cycles → point1 goes 0→1 exactly once, state SERVE_WAIT, counter restarts at 60.
- Raise miss_left and miss_right in the same cycle during PLAY → point1 and point2 unchanged, next serve after 60 ticks.
- Set pausa=1 for 30 ticks during SERVE_WAIT, and pulse miss_left while paused in PLAY → no countdown progress, no score change.
- Score player 2 to 10 → point2=10, game_over=1, winner=1; after 180 ticks scores become 0, game_over=0, serve_dir=0, serve follows 60 ticks later.
- Assert rst mid-countdown at point1=7 → all outputs return to reset values asynchronously, before the next clock edge.
